gray_codec_pipe: RTL and testbench
==================================

Name: gray_codec_pipe

Overview:
- Parametrised, registered successor to the team's fixed 4-bit binary-to-Gray converter.
- Converts WIDTH-bit words in either direction, selected per transaction: binary->Gray or Gray->binary.
- Uses a valid/ready handshake with one output register stage.
- In Gray->binary mode, checks that successive Gray inputs obey the single-bit-step rule and counts violations. Used on counter values that cross clock domains.

Parameters:
- WIDTH, 4, data word width in bits; legal range 2..32.
- CNT_W, 8, width of the saturating step-error counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept input this cycle.
- in_mode  input  1  0 = binary->Gray, 1 = Gray->binary.
- in_data  input  WIDTH  word to convert; bit WIDTH-1 is MSB.
- out_valid  output  1  out_data holds a converted word.
- out_ready  input  1  downstream accepts output this cycle.
- out_data  output  WIDTH  converted word.
- out_mode  output  1  in_mode of the word held in out_data.
- step_err  output  1  qualifies out_data: the Gray input broke the single-bit-step rule.
- err_count  output  CNT_W  total step errors since reset; saturating.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_mode=0, step_err=0, err_count=0, history valid flag hist_v=0, history register hist=0.
  - in_ready is combinational, so it reads 1 while in reset.
- Accept: input is taken when in_valid && in_ready.
- Flow control: in_ready = !out_valid || out_ready (full-throughput; no combinational path from in_valid to in_ready).
- Latency: exactly one clock. A word accepted in cycle N appears on out_* in cycle N+1.
- Output hold: if out_valid && !out_ready, out_data, out_mode and step_err hold stable and in_ready=0.
- Draining: a transfer out with no new accept clears out_valid; out_data keeps its last value.
- Simultaneous transfer out and accept: the register reloads with the new word and out_valid stays 1.
- Binary->Gray (in_mode=0):
  - G[WIDTH-1]=B[WIDTH-1].
  - G[i]=B[i+1]^B[i] for i<WIDTH-1.
  - step_err=0. History and hist_v are not touched.
- Gray->binary (in_mode=1):
  - B[WIDTH-1]=G[WIDTH-1].
  - B[i]=B[i+1]^G[i], a prefix XOR from the MSB down, evaluated in one cycle.
- Step check (in_mode=1 accepts only):
  - d = popcount(in_data ^ hist).
  - step_err = hist_v && (d > 1). d=0 (repeat) and d=1 are legal.
  - On the same edge: hist <= in_data, hist_v <= 1.
  - The first mode-1 word after reset never flags.
  - Mode-0 words between mode-1 words do not break the comparison chain.
- err_count:
  - Increments by 1 on the accept edge of each word that raises step_err, not at output transfer.
  - Saturates at 2^CNT_W-1 and never wraps.
- Wrap-around: Gray values all-ones-MSB-only to zero differ in one bit and are legal (e.g. WIDTH=4: 1000 -> 0000).
- Reset mid-operation: any held output word is discarded, out_valid drops immediately, history and counter are cleared.
- Back-pressure: no input is lost or duplicated. Every accepted word produces exactly one output transfer, in order.

Test Plan:
- WIDTH=4, out_ready=1, mode 0, inputs 0..15 one per cycle -> out_data 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, one cycle after each accept; step_err=0 throughout.
- Mode 1 input 4'b1110 -> out_data 4'b1011. Then input 4'b1011 -> out_data 4'b1101 with step_err=1 (2 bits differ) and err_count=1.
- Mode 1 sequence 0000,0001,0001,0011,1000,0000 -> step_err 0,0,0,0,1,0; err_count ends at 1. The repeat is legal, 0011->1000 (3 bits) flags, and the 1000->0000 wrap is legal.
- out_ready held 0 for 5 cycles with in_valid=1 -> in_ready=0 after first accept and out_data stable. Release out_ready -> remaining words emerge in order with no gaps or duplicates.
- CNT_W=2, drive 5 illegal mode-1 steps -> err_count 1,2,3,3,3 (saturates, no wrap).
- Assert rst asynchronously mid-stream with out_valid=1 -> out_valid=0, err_count=0 before the next clock edge. The next mode-1 word after release gives step_err=0 regardless of value.

Source files
------------

// File: rtl/gray_codec_pipe.sv
// Registered binary<->Gray converter with a valid/ready handshake and a
// single-bit-step check on successive Gray inputs (saturating error count).
module gray_codec_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             step_err,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] hist_r;
  logic             hist_v_r;
  logic [WIDTH-1:0] conv_s;
  logic             viol_s;
  logic             accept_s;
  logic             cnt_sat_s;

  function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
    return b ^ {1'b0, b[WIDTH-1:1]};
  endfunction

  // Prefix XOR from the MSB down.
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = g;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // True when more than one bit of x is set.
  function automatic logic multi_bit(input logic [WIDTH-1:0] x);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      multi = multi | (seen & x[i]);
      seen  = seen | x[i];
    end
    return multi;
  endfunction

  assign in_ready  = !out_valid || out_ready;
  assign accept_s  = in_valid && in_ready;
  assign cnt_sat_s = (err_count == CNT_MAX);

  // Conversion result and step-rule verdict for the word on the input.
  always_comb begin
    conv_s = {WIDTH{1'b0}};
    viol_s = 1'b0;
    if (in_mode) begin
      conv_s = gray_to_bin(in_data);
      viol_s = hist_v_r && multi_bit(in_data ^ hist_r);
    end else begin
      conv_s = bin_to_gray(in_data);
      viol_s = 1'b0;
    end
  end

  // Output register stage: load on accept, clear valid on a drain-only transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= {WIDTH{1'b0}};
      out_mode  <= 1'b0;
      step_err  <= 1'b0;
    end else if (accept_s) begin
      out_valid <= 1'b1;
      out_data  <= conv_s;
      out_mode  <= in_mode;
      step_err  <= viol_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Last accepted Gray word; binary->Gray traffic leaves the chain untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_r   <= {WIDTH{1'b0}};
      hist_v_r <= 1'b0;
    end else if (accept_s && in_mode) begin
      hist_r   <= in_data;
      hist_v_r <= 1'b1;
    end
  end

  // Saturating step-error counter, bumped on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= {CNT_W{1'b0}};
    end else if (accept_s && viol_s && !cnt_sat_s) begin
      err_count <= err_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Scoreboard bench for gray_codec_pipe: two instances (CNT_W 8 and 2) share
// all inputs; a table-based Gray model predicts every output transfer.
module tb_gray_codec_pipe;

  localparam int W   = 4;
  localparam int CW  = 8;
  localparam int CW2 = 2;

  typedef struct {
    logic [W-1:0] data;
    logic         mode;
    logic         err;
    int           cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_mode = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          out_ready = 1'b1;
  logic          in_ready, in_ready2;
  logic          out_valid, out_valid2;
  logic [W-1:0]  out_data, out_data2;
  logic          out_mode, out_mode2;
  logic          step_err, step_err2;
  logic [CW-1:0] err_count;
  logic [CW2-1:0] err_count2;

  int checks = 0;
  int passes = 0;
  int ready_mode = 0;   // 0: always ready, 1: held low, 2: random

  logic [W-1:0] gtab [2**W];
  logic [W-1:0] hist_m = '0;
  logic         hist_v_m = 1'b0;
  int           cnt_m = 0;
  exp_t         sbq [$];

  gray_codec_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
    .step_err(step_err), .err_count(err_count)
  );

  gray_codec_pipe #(.WIDTH(W), .CNT_W(CW2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_mode(out_mode2),
    .step_err(step_err2), .err_count(err_count2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int sat(input int c, input int bits);
    int mx;
    mx = (1 << bits) - 1;
    return (c > mx) ? mx : c;
  endfunction

  function automatic logic [W-1:0] ref_b2g(input logic [W-1:0] b);
    return gtab[b];
  endfunction

  function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
    for (int i = 0; i < 2**W; i++) begin
      if (gtab[i] == g) return W'(i);
    end
    return '0;
  endfunction

  task automatic model_accept(input logic m, input logic [W-1:0] d);
    exp_t e;
    e.mode = m;
    e.err  = 1'b0;
    if (m) begin
      e.data = ref_g2b(d);
      if (hist_v_m && $countones(d ^ hist_m) > 1) e.err = 1'b1;
      hist_m   = d;
      hist_v_m = 1'b1;
    end else begin
      e.data = ref_b2g(d);
    end
    if (e.err) cnt_m++;
    e.cnt = cnt_m;
    sbq.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the word is accepted.
  task automatic send(input logic m, input logic [W-1:0] d);
    int  waited;
    bit  done;
    waited = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(m, d);
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 40) begin
          chk("accept_timeout", 32'd0, 32'd1);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_all_words", 32'(sbq.size()), 32'd0);
  endtask

  // Asynchronous assert between edges, release away from the rising edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_err_count2", 32'(err_count2), 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    hist_v_m = 1'b0;
    hist_m   = '0;
    cnt_m    = 0;
    @(posedge clk);
    #1;
  endtask

  // Downstream ready generator.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: handshake model and scoreboard pop on every output transfer.
  initial begin
    logic ov_exp;
    exp_t e;
    ov_exp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ov_exp = 1'b0;
        sbq.delete();
      end else begin
        chk("out_valid", 32'(out_valid), 32'(ov_exp));
        chk("out_valid2", 32'(out_valid2), 32'(ov_exp));
        chk("in_ready", 32'(in_ready), 32'(!ov_exp || out_ready));
        chk("in_ready2", 32'(in_ready2), 32'(!ov_exp || out_ready));
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
          end else begin
            e = sbq.pop_front();
            chk("out_data", 32'(out_data), 32'(e.data));
            chk("out_mode", 32'(out_mode), 32'(e.mode));
            chk("step_err", 32'(step_err), 32'(e.err));
            chk("err_count", 32'(err_count), 32'(sat(e.cnt, CW)));
            chk("out_data2", 32'(out_data2), 32'(e.data));
            chk("out_mode2", 32'(out_mode2), 32'(e.mode));
            chk("step_err2", 32'(step_err2), 32'(e.err));
            chk("err_count2", 32'(err_count2), 32'(sat(e.cnt, CW2)));
          end
        end
        ov_exp = (in_valid && (!ov_exp || out_ready)) || (ov_exp && !out_ready);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1);
  end

  // Main stimulus.
  initial begin
    logic [W-1:0] d;
    logic         m;

    // Reflected Gray table built by mirroring.
    gtab[0] = '0;
    gtab[1] = W'(1);
    for (int k = 1; k < W; k++) begin
      for (int i = 0; i < (1 << k); i++) begin
        gtab[(1 << k) + i] = gtab[(1 << k) - 1 - i] | W'(1 << k);
      end
    end

    #1;
    rst = 1'b1;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_out_mode", 32'(out_mode), 32'd0);
    chk("reset_step_err", 32'(step_err), 32'd0);
    chk("reset_err_count", 32'(err_count), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Binary->Gray over the full range, back-to-back.
    for (int i = 0; i < 16; i++) send(1'b0, W'(i));
    wait_drain();

    // Gray->binary with a two-bit step.
    send(1'b1, 4'b1110);
    send(1'b1, 4'b1011);
    wait_drain();

    // Repeat, legal steps, one illegal jump and the wrap-around.
    do_reset();
    send(1'b1, 4'b0000);
    send(1'b1, 4'b0001);
    send(1'b1, 4'b0001);
    send(1'b1, 4'b0011);
    send(1'b1, 4'b1000);
    send(1'b1, 4'b0000);
    wait_drain();
    chk("seq_err_count", 32'(err_count), 32'd1);

    // Back-pressure: downstream stalls while input keeps offering words.
    ready_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 6; i++) send(1'b0, W'(i + 3));
      end
      begin
        repeat (6) @(posedge clk);
        ready_mode = 0;
      end
    join
    wait_drain();

    // Saturation of the narrow counter.
    do_reset();
    send(1'b1, 4'b0000);
    for (int i = 0; i < 5; i++) send(1'b1, (i % 2 == 0) ? 4'b0011 : 4'b0000);
    wait_drain();
    chk("sat_err_count2", 32'(err_count2), 32'd3);
    chk("sat_err_count", 32'(err_count), 32'd5);

    // Randomized traffic with random back-pressure and idle gaps.
    ready_mode = 2;
    for (int n = 0; n < 300; n++) begin
      m = 1'($urandom_range(0, 1));
      if (m && $urandom_range(0, 3) != 0) d = hist_m ^ (W'(1) << $urandom_range(0, W)) & W'(4'b1111);
      else d = W'($urandom_range(0, 2**W - 1));
      send(m, d);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    ready_mode = 0;
    wait_drain();

    // Reset while a word is held; history and counter must clear.
    send(1'b1, 4'b0000);
    send(1'b1, 4'b0101);
    wait_drain();
    ready_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    send(1'b1, 4'b1111);
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    ready_mode = 0;
    send(1'b1, 4'b1010);
    wait_drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
